// File: rtl/cmu_fp_arbiter_if.sv
// Signal bundle between CMU requesters, the shared FP unit and the cmu_fp_arbiter.
// The slave modport is the arbiter's view; master is the requester/FP-unit side.
interface cmu_fp_arbiter_if #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DBL_WIDTH = 64
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           req_op;
  logic [NREQ*DBL_WIDTH-1:0] req_a;
  logic [NREQ*DBL_WIDTH-1:0] req_b;
  logic                      fu_valid;
  logic                      fu_op;
  logic [DBL_WIDTH-1:0]      fu_a;
  logic [DBL_WIDTH-1:0]      fu_b;
  logic                      fu_finish;
  logic [DBL_WIDTH-1:0]      fu_result;
  logic [NREQ-1:0]           rsp_valid;
  logic [DBL_WIDTH-1:0]      rsp_data;
  logic                      busy;
  logic                      err_underflow;

  modport slave (
    input  req_valid, req_op, req_a, req_b, fu_finish, fu_result,
    output req_ready, fu_valid, fu_op, fu_a, fu_b, rsp_valid, rsp_data, busy, err_underflow
  );

  modport master (
    output req_valid, req_op, req_a, req_b, fu_finish, fu_result,
    input  req_ready, fu_valid, fu_op, fu_a, fu_b, rsp_valid, rsp_data, busy, err_underflow
  );
endinterface

// File: rtl/cmu_fp_arbiter.sv
// Round-robin sharing of one pipelined FP add/mul unit among NREQ CMU channels;
// an in-order tag FIFO routes each returned result back to its issuing requester.
module cmu_fp_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DBL_WIDTH = 64,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IDW       = $clog2(NREQ)
) (
  input logic             clk,
  input logic             rst_n,
  cmu_fp_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [IDW-1:0]       tag_mem_q [DEPTH];
  logic                 fu_valid_q, fu_op_q;
  logic [DBL_WIDTH-1:0] fu_a_q, fu_b_q, rsp_data_q;
  logic [NREQ-1:0]      rsp_valid_q, grant;
  logic                 err_q;
  logic                 clock_en, accept, pop;
  logic [IDW-1:0]       grant_id, head_tag;
  logic [IDW:0]         scan;

  assign clock_en = (count_q < CW'(DEPTH));
  assign pop      = bus.fu_finish && (count_q != '0);
  assign head_tag = tag_mem_q[rd_ptr_q];

  // Scan upward from rr_ptr with wrap; NREQ need not be a power of two.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    scan     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
      if (scan >= (IDW + 1)'(NREQ)) scan = scan - (IDW + 1)'(NREQ);
      if (!accept && bus.req_valid[scan[IDW-1:0]]) begin
        accept   = 1'b1;
        grant_id = scan[IDW-1:0];
      end
    end
    // No grant while the tag FIFO is full or reset is held.
    if (!clock_en || !rst_n) accept = 1'b0;
    if (accept) grant[grant_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fu_valid_q  <= 1'b0;
      fu_op_q     <= 1'b0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      fu_valid_q <= accept;
      if (accept) begin
        fu_op_q  <= bus.req_op[grant_id];
        fu_a_q   <= bus.req_a[grant_id*DBL_WIDTH +: DBL_WIDTH];
        fu_b_q   <= bus.req_b[grant_id*DBL_WIDTH +: DBL_WIDTH];
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      rsp_valid_q <= '0;
      if (pop) begin
        rsp_valid_q <= NREQ'(1) << head_tag;
        rsp_data_q  <= bus.fu_result;
        rd_ptr_q    <= rd_ptr_q + 1'b1;
      end
      if (bus.fu_finish && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (accept) tag_mem_q[wr_ptr_q] <= grant_id;
  end

  assign bus.req_ready     = grant;
  assign bus.fu_valid      = fu_valid_q;
  assign bus.fu_op         = fu_op_q;
  assign bus.fu_a          = fu_a_q;
  assign bus.fu_b          = fu_b_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.busy          = (count_q != '0);
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_cmu_fp_arbiter.sv
// Bench for cmu_fp_arbiter: queue-based reference model checked every cycle,
// a latency-3 FP unit model, and directed scenarios with literal expectations.
module tb_cmu_fp_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cmu_fp_arbiter_if #(.NREQ(NREQ), .DBL_WIDTH(DW)) bus ();

  cmu_fp_arbiter #(
    .NREQ(NREQ), .DBL_WIDTH(DW), .DEPTH(DEPTH), .IDW(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_rr;
  int          m_q[$];
  logic        m_fu_valid, m_fu_op, m_err;
  logic [63:0] m_fu_a, m_fu_b, m_rsp_data;
  logic [3:0]  m_rsp_valid;
  // Inputs captured at the previous compare point
  int          s_grant = -1;
  logic        s_fin = 1'b0, s_op = 1'b0;
  logic [63:0] s_res = '0, s_a = '0, s_b = '0;
  bit          prev_rst = 1'b0;

  function automatic int exp_grant();
    if (!rst_n || m_q.size() >= DEPTH) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Single compare process: advance the model by the edge just passed, then compare.
  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    if (prev_rst) begin
      if (s_fin) begin
        if (m_q.size() > 0) begin
          m_rsp_valid = 4'(1 << m_q.pop_front());
          m_rsp_data  = s_res;
        end else begin
          m_rsp_valid = 4'b0;
          m_err       = 1'b1;
        end
      end else begin
        m_rsp_valid = 4'b0;
      end
      if (s_grant >= 0) begin
        m_fu_valid = 1'b1;
        m_fu_op    = s_op;
        m_fu_a     = s_a;
        m_fu_b     = s_b;
        m_q.push_back(s_grant);
        m_rr = (s_grant + 1) % NREQ;
      end else begin
        m_fu_valid = 1'b0;
      end
    end
    if (!rst_n) begin
      m_rr = 0; m_q.delete(); m_fu_valid = 0; m_fu_op = 0; m_err = 0;
      m_fu_a = '0; m_fu_b = '0; m_rsp_data = '0; m_rsp_valid = '0;
    end
    g  = exp_grant();
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    check("req_ready", 64'(bus.req_ready), 64'(er));
    check("fu_valid", 64'(bus.fu_valid), 64'(m_fu_valid));
    check("fu_op", 64'(bus.fu_op), 64'(m_fu_op));
    check("fu_a", bus.fu_a, m_fu_a);
    check("fu_b", bus.fu_b, m_fu_b);
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_valid));
    check("rsp_data", bus.rsp_data, m_rsp_data);
    check("busy", 64'(bus.busy), 64'(m_q.size() != 0));
    check("err_underflow", 64'(bus.err_underflow), 64'(m_err));
    s_grant = g;
    s_fin   = bus.fu_finish;
    s_res   = bus.fu_result;
    if (g >= 0) begin
      s_op = bus.req_op[g];
      s_a  = bus.req_a[g*64 +: 64];
      s_b  = bus.req_b[g*64 +: 64];
    end
    prev_rst = rst_n;
  end

  // Shared FP unit model: result due 3 cycles after fu_valid, in order.
  int          cyc = 0;
  bit          auto_fu = 1'b0;
  logic [63:0] p_res[$];
  int          p_due[$];

  function automatic logic [63:0] fp_calc(input logic op, input logic [63:0] a,
                                          input logic [63:0] b);
    real r;
    r = op ? $bitstoreal(a) * $bitstoreal(b) : $bitstoreal(a) + $bitstoreal(b);
    return $realtobits(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (bus.fu_valid === 1'b1) begin
      p_res.push_back(fp_calc(bus.fu_op, bus.fu_a, bus.fu_b));
      p_due.push_back(cyc + 3);
    end
    if (auto_fu) begin
      if (p_due.size() > 0 && p_due[0] <= cyc) begin
        bus.fu_finish = 1'b1;
        bus.fu_result = p_res.pop_front();
        void'(p_due.pop_front());
      end else begin
        bus.fu_finish = 1'b0;
      end
    end
  endtask

  task automatic drive(input int i, input bit op, input real a, input real b);
    bus.req_op[i]          = op;
    bus.req_a[i*64 +: 64]  = $realtobits(a);
    bus.req_b[i*64 +: 64]  = $realtobits(b);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.fu_finish = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    p_res.delete();
    p_due.delete();
  endtask

  function automatic int onehot_id(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      4'b0000: return -1;
      default: return 99;
    endcase
  endfunction

  task automatic wait_rsp(output logic [3:0] rv, output logic [63:0] rd);
    rv = '0;
    rd = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.rsp_valid != 0) begin
        rv = bus.rsp_valid;
        rd = bus.rsp_data;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && bus.busy; k++) tick();
  endtask

  logic [3:0]  rv;
  logic [63:0] rd;
  int          acc;
  int          rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int          alt_exp[4] = '{0, 2, 0, 2};
  logic [3:0]  tr_v[3];
  logic [63:0] tr_d[3];
  logic        tr_busy;
  int          n;

  initial begin
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.fu_finish = 1'b0; bus.fu_result = '0;
    #1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    auto_fu = 1'b1;

    // Single op: 1.0 + 2.0 from requester 0
    drive(0, 1'b0, 1.0, 2.0);
    bus.req_valid = 4'b0001;
    #1 check("single_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    check("single_fu_valid", 64'(bus.fu_valid), 64'h1);
    check("single_fu_a", bus.fu_a, 64'h3FF0000000000000);
    wait_rsp(rv, rd);
    check("single_rsp_valid", 64'(rv), 64'h1);
    check("single_rsp_data", rd, 64'h4008000000000000);
    check("single_busy_after", 64'(bus.busy), 64'h0);

    // Round-robin fairness
    do_reset();
    for (int i = 0; i < NREQ; i++) drive(i, i[0], real'(i) + 1.0, 0.5);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_grant", 64'(onehot_id(bus.req_ready)), 64'(rr_exp[k]));
      tick();
    end
    bus.req_valid = 4'b0100;
    #1 check("rr_set_ptr3", 64'(onehot_id(bus.req_ready)), 64'd2);
    tick();
    bus.req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_alt_grant", 64'(onehot_id(bus.req_ready)), 64'(alt_exp[k]));
      tick();
    end
    bus.req_valid = '0;
    wait_idle();
    check("rr_drained", 64'(bus.busy), 64'h0);

    // Tag routing: mul r3, add r1, mul r3
    drive(3, 1'b1, 3.0, 2.0);
    bus.req_valid = 4'b1000;
    tick();
    drive(1, 1'b0, 1.0, 4.0);
    bus.req_valid = 4'b0010;
    tick();
    drive(3, 1'b1, 1.5, 3.0);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    n = 0;
    tr_busy = 1'b1;
    for (int k = 0; k < 20 && n < 3; k++) begin
      tick();
      if (bus.rsp_valid != 0) begin
        tr_v[n] = bus.rsp_valid;
        tr_d[n] = bus.rsp_data;
        n++;
        if (n == 3) tr_busy = bus.busy;
      end
    end
    check("tag_count", 64'(n), 64'd3);
    check("tag_v0", 64'(tr_v[0]), 64'h8);
    check("tag_d0", tr_d[0], 64'h4018000000000000);
    check("tag_v1", 64'(tr_v[1]), 64'h2);
    check("tag_d1", tr_d[1], 64'h4014000000000000);
    check("tag_v2", 64'(tr_v[2]), 64'h8);
    check("tag_d2", tr_d[2], 64'h4012000000000000);
    check("tag_busy_fall", 64'(tr_busy), 64'h0);

    // Full: unit never finishes
    do_reset();
    auto_fu = 1'b0;
    bus.req_valid = 4'b1111;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      #1 if (bus.req_ready != 0) acc++;
      tick();
    end
    check("full_accepts", 64'(acc), 64'd8);
    bus.fu_finish = 1'b1;
    bus.fu_result = 64'h1111;
    #1 check("full_no_bypass", 64'(bus.req_ready), 64'h0);
    tick();
    bus.fu_finish = 1'b0;
    #1 check("full_one_more", 64'(bus.req_ready), 64'h1);
    tick();
    #1 check("full_again", 64'(bus.req_ready), 64'h0);
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      bus.fu_finish = 1'b1;
      bus.fu_result = 64'(k + 16'h2000);
      tick();
    end
    // count is 5: accept and pop together
    bus.req_valid = 4'b0001;
    bus.fu_result = 64'h3333;
    #1 check("acc_pop_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    check("acc_pop_busy_at1", 64'(bus.busy), 64'h1);
    tick();
    check("acc_pop_busy_at0", 64'(bus.busy), 64'h0);
    bus.fu_finish = 1'b0;

    // Underflow
    tick();
    bus.fu_finish = 1'b1;
    tick();
    bus.fu_finish = 1'b0;
    check("uf_err", 64'(bus.err_underflow), 64'h1);
    check("uf_rsp", 64'(bus.rsp_valid), 64'h0);
    tick(); tick(); tick();
    check("uf_sticky", 64'(bus.err_underflow), 64'h1);
    p_res.delete();
    p_due.delete();
    auto_fu = 1'b1;
    drive(2, 1'b0, 1.0, 1.0);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    wait_rsp(rv, rd);
    check("uf_after_v", 64'(rv), 64'h4);
    check("uf_after_d", rd, 64'h4000000000000000);

    // Reset mid-flight
    auto_fu = 1'b0;
    bus.fu_finish = 1'b0;
    drive(0, 1'b0, 2.0, 2.0);
    bus.req_valid = 4'b0001;
    tick(); tick(); tick();
    check("mid_busy", 64'(bus.busy), 64'h1);
    drive(1, 1'b1, 2.0, 3.0);
    bus.req_valid = 4'b0010;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("rst_ready", 64'(bus.req_ready), 64'h0);
      check("rst_fu_valid", 64'(bus.fu_valid), 64'h0);
      check("rst_fu_a", bus.fu_a, 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_err", 64'(bus.err_underflow), 64'h0);
      tick();
    end
    rst_n = 1'b1;
    p_res.delete();
    p_due.delete();
    #1 check("post_rst_grant", 64'(bus.req_ready), 64'h2);
    check("post_rst_busy", 64'(bus.busy), 64'h0);
    auto_fu = 1'b1;
    tick();
    bus.req_valid = '0;
    wait_rsp(rv, rd);
    check("post_rst_rsp_v", 64'(rv), 64'h2);
    check("post_rst_rsp_d", rd, 64'h4018000000000000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
